// File: rtl/fetch_pc_sequencer_if.sv
// Fetch-stage bus between the PC sequencer and its environment (instruction memory,
// IF/ID register, execute redirect).
interface fetch_pc_sequencer_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instruction;
  logic [31:0] AddressBus;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        halted;
  logic        align_fault;

  modport master (
    input  stall, redirect_valid, redirect_target, instruction,
    output AddressBus, pc_plus4, fetch_valid, halted, align_fault
  );

  modport slave (
    output stall, redirect_valid, redirect_target, instruction,
    input  AddressBus, pc_plus4, fetch_valid, halted, align_fault
  );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Instruction-fetch PC sequencer: sequential, early J-type jump, late redirect, or stop.
// Optional macro PC_ALIGN_CHECK_EN: misaligned redirects halt and set sticky align_fault.
//
//  state | meaning
//  BOOT  | one cycle after reset, no fetch; memory read settles
//  RUN   | one fetch per cycle unless stalled
//  HALT  | stop word seen (or faulting redirect); waits for a redirect
module fetch_pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0004,
  parameter logic [4:0]  J_FUNC      = 5'b00000,
  parameter logic [1:0]  J_TYPE_CODE = 2'b10
) (
  input  logic                       clock,
  input  logic                       reset,
  fetch_pc_sequencer_if.master       bus
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic        fault, fault_next;

  logic [4:0]  func;
  logic [23:0] imm;
  logic [1:0]  itype;
  logic        stop;
  logic        is_jump;
  logic [31:0] jump_offset;
  logic [31:0] target_aligned;
  logic        target_misaligned;

  assign func        = bus.instruction[31:27];
  assign imm         = bus.instruction[26:3];
  assign itype       = bus.instruction[2:1];
  assign stop        = bus.instruction[0];
  assign is_jump     = (func == J_FUNC) && (itype == J_TYPE_CODE);
  assign jump_offset = {{6{imm[23]}}, imm, 2'b00};

  assign target_aligned = bus.redirect_target & 32'hFFFF_FFFC;
`ifdef PC_ALIGN_CHECK_EN
  assign target_misaligned = |bus.redirect_target[1:0];
`else
  assign target_misaligned = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      fault <= fault_next;
    end
  end

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    fault_next      = fault;
    bus.fetch_valid = 1'b0;
    bus.halted      = 1'b0;

    case (state)
      BOOT: begin
        state_next = RUN;
        if (bus.redirect_valid) begin
          if (target_misaligned) begin
            state_next = HALT;
            fault_next = 1'b1;
          end else begin
            pc_next = target_aligned;
          end
        end
      end
      RUN: begin
        bus.fetch_valid = ~bus.stall;
        if (bus.redirect_valid) begin
          if (target_misaligned) begin
            state_next = HALT;
            fault_next = 1'b1;
          end else begin
            pc_next = target_aligned;
          end
        end else if (bus.stall) begin
          pc_next = pc;
        end else if (stop) begin
          state_next = HALT;
        end else if (is_jump) begin
          pc_next = pc + jump_offset;
        end else begin
          pc_next = pc + 32'd4;
        end
      end
      HALT: begin
        bus.halted = 1'b1;
        if (bus.redirect_valid) begin
          if (target_misaligned) begin
            fault_next = 1'b1;
          end else begin
            state_next = RUN;
            pc_next    = target_aligned;
          end
        end
      end
      default: begin
        state_next = BOOT;
        pc_next    = RESET_PC;
      end
    endcase
  end

  assign bus.AddressBus = pc;
  assign bus.pc_plus4   = pc + 32'd4;
`ifdef PC_ALIGN_CHECK_EN
  assign bus.align_fault = fault;
`else
  assign bus.align_fault = 1'b0;
`endif

endmodule
